// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: initiator-side controller for the unit SRAM macro wrapper.
// Accepts single writes and read bursts on a valid/ready command port, drives
// registered SRAM pins, and returns read data READ_LATENCY cycles after each
// beat as a strobe-only response stream.
// Optional build macro SRAM_ACC_PERF_CNT_EN adds saturating beat counters
// (perf_rd_beats, perf_wr_beats) with a synchronous clear input (perf_clr).
module sram_access_ctrl #(
  parameter int READ_LATENCY   = 4,
  parameter int MAX_BURST_LOG2 = 4
) (
  input  logic                      sram_clk,
  input  logic                      rst_n,
`ifdef SRAM_ACC_PERF_CNT_EN
  input  logic                      perf_clr,
  output logic [15:0]               perf_rd_beats,
  output logic [15:0]               perf_wr_beats,
`endif
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [11:0]               cmd_addr,
  input  logic [1:0]                cmd_conf,
  input  logic [MAX_BURST_LOG2-1:0] cmd_len,
  input  logic [31:0]               cmd_wdata,
  output logic                      rsp_valid,
  output logic [31:0]               rsp_data,
  output logic                      rsp_last,
  output logic                      busy,
  output logic                      sram_csb,
  output logic                      sram_web,
  output logic [11:0]               sram_addr,
  output logic [1:0]                sram_conf,
  output logic [31:0]               sram_din,
  input  logic [31:0]               sram_dout
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_e;

  state_e                    state_q, state_d;
  logic                      cmd_ready_q, cmd_ready_d;
  logic [MAX_BURST_LOG2-1:0] beats_left_q, beats_left_d;
  logic                      csb_q, csb_d;
  logic                      web_q, web_d;
  logic [11:0]               addr_q, addr_d;
  logic [1:0]                conf_q, conf_d;
  logic [31:0]               din_q, din_d;
  logic                      pin_last_q, pin_last_d;
  logic [READ_LATENCY-1:0]   pipe_vld_q, pipe_vld_d;
  logic [READ_LATENCY-1:0]   pipe_last_q, pipe_last_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      rsp_last_q, rsp_last_d;
  logic [31:0]               rsp_data_q, rsp_data_d;
  logic                      handshake;
  logic                      rd_beat_on_pins;

  assign handshake       = cmd_valid & cmd_ready_q;
  assign rd_beat_on_pins = ~csb_q & web_q;

  // Next-state and next-pin computation; pins carry the beat for the coming cycle.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    state_d      = state_q;
    beats_left_d = beats_left_q;
    csb_d        = 1'b1;
    web_d        = 1'b1;
    addr_d       = addr_q;
    conf_d       = conf_q;
    din_d        = din_q;
    pin_last_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (handshake) begin
          addr_d = cmd_addr;
          conf_d = (cmd_conf == 2'b11) ? 2'b00 : cmd_conf;  // reserved width runs as 32b
          din_d  = cmd_wdata;
          csb_d  = 1'b0;
          if (cmd_write) begin
            web_d   = 1'b0;
            state_d = WRITE;
          end else begin
            beats_left_d = cmd_len;
            pin_last_d   = (cmd_len == '0);
            state_d      = READ;
          end
        end
      end
      WRITE: state_d = IDLE;
      READ: begin
        if (beats_left_q == '0) begin
          state_d = DRAIN;
        end else begin
          csb_d        = 1'b0;
          addr_d       = {addr_q[11:10], addr_q[9:0] + 10'd1};  // word address wraps inside the lane
          beats_left_d = beats_left_q - MAX_BURST_LOG2'(1);
          pin_last_d   = (beats_left_q == MAX_BURST_LOG2'(1));
        end
      end
      DRAIN: if (pipe_vld_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
  end

  // Control state and registered SRAM pins.
  always_ff @(posedge sram_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b0;
      beats_left_q <= '0;
      csb_q        <= 1'b1;
      web_q        <= 1'b1;
      addr_q       <= '0;
      conf_q       <= '0;
      din_q        <= '0;
      pin_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      beats_left_q <= beats_left_d;
      csb_q        <= csb_d;
      web_q        <= web_d;
      addr_q       <= addr_d;
      conf_q       <= conf_d;
      din_q        <= din_d;
      pin_last_q   <= pin_last_d;
    end
  end

  // Latency tracking: a token follows each read beat and marks when its data lands.
  always_comb begin
    pipe_vld_d  = {pipe_vld_q[READ_LATENCY-2:0], rd_beat_on_pins};
    pipe_last_d = {pipe_last_q[READ_LATENCY-2:0], rd_beat_on_pins & pin_last_q};
    rsp_valid_d = pipe_vld_q[READ_LATENCY-1];
    rsp_last_d  = pipe_vld_q[READ_LATENCY-1] & pipe_last_q[READ_LATENCY-1];
    rsp_data_d  = pipe_vld_q[READ_LATENCY-1] ? sram_dout : rsp_data_q;
  end

  // Token pipe and response registers.
  always_ff @(posedge sram_clk) begin
    if (!rst_n) begin
      // NOTE: the token pipe is reset like any control flop; a reset mid-burst must flush it.
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      pipe_vld_q  <= pipe_vld_d;
      pipe_last_q <= pipe_last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

`ifdef SRAM_ACC_PERF_CNT_EN
  logic [15:0] perf_rd_q, perf_rd_d;
  logic [15:0] perf_wr_q, perf_wr_d;

  // Saturating beat counters; a clear request overrides a coincident beat.
  always_comb begin
    perf_rd_d = perf_rd_q;
    perf_wr_d = perf_wr_q;
    if (perf_clr) begin
      perf_rd_d = '0;
      perf_wr_d = '0;
    end else begin
      if (!csb_d && web_d && perf_rd_q != 16'hFFFF)  perf_rd_d = perf_rd_q + 16'd1;
      if (!csb_d && !web_d && perf_wr_q != 16'hFFFF) perf_wr_d = perf_wr_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge sram_clk) begin
    if (!rst_n) begin
      perf_rd_q <= '0;
      perf_wr_q <= '0;
    end else begin
      perf_rd_q <= perf_rd_d;
      perf_wr_q <= perf_wr_d;
    end
  end

  assign perf_rd_beats = perf_rd_q;
  assign perf_wr_beats = perf_wr_q;
`endif

  assign cmd_ready = cmd_ready_q;
  assign busy      = (state_q != IDLE);
  assign sram_csb  = csb_q;
  assign sram_web  = web_q;
  assign sram_addr = addr_q;
  assign sram_conf = conf_q;
  assign sram_din  = din_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_data  = rsp_data_q;

endmodule
